// File: rtl/sampling1_pkg.sv
// Shared types and constants for the layer-1 pooled frame buffer.
// One pooled frame is 6 channels of 14x14 16-bit pixels.
package sampling1_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int MAP_W      = 14;
    localparam int MAP_H      = 14;
    localparam int DEPTH      = MAP_W * MAP_H;
    localparam int ADDR_W     = 8;
    localparam int NUM_CH     = 6;
    localparam int PIX_W      = NUM_CH * DATA_WIDTH;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

    // Buffer phase: capture the stream, then replay it.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Six channels side by side; channel 1 occupies the low bits.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] ch6;
        logic [DATA_WIDTH-1:0] ch5;
        logic [DATA_WIDTH-1:0] ch4;
        logic [DATA_WIDTH-1:0] ch3;
        logic [DATA_WIDTH-1:0] ch2;
        logic [DATA_WIDTH-1:0] ch1;
    } pix6_t;

endpackage

// File: rtl/sampling1_buf_ram.sv
// Simple dual-port frame store, one word per raster position.
// Read data is registered and holds while no read is issued.
module sampling1_buf_ram
    import sampling1_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  pix6_t             i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output pix6_t             o_rdata
);

    pix6_t r_mem [DEPTH];
    pix6_t r_rdata;

    // Write port: store all six channels of one pixel.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: the output register doubles as a pipeline stage.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sampling1_frame_buffer.sv
// Captures one pooled 6-channel frame from the free-running sampler
// and replays it in raster order over a valid/ready handshake.
module sampling1_frame_buffer
    import sampling1_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Input_Reset_n,
    input  logic                  Input_Valid,
    input  logic                  Input_Finish,
    input  logic [DATA_WIDTH-1:0] Input_Pixel_1,
    input  logic [DATA_WIDTH-1:0] Input_Pixel_2,
    input  logic [DATA_WIDTH-1:0] Input_Pixel_3,
    input  logic [DATA_WIDTH-1:0] Input_Pixel_4,
    input  logic [DATA_WIDTH-1:0] Input_Pixel_5,
    input  logic [DATA_WIDTH-1:0] Input_Pixel_6,
    output logic                  Input_Ready,
    output logic [DATA_WIDTH-1:0] Output_Pixel_1,
    output logic [DATA_WIDTH-1:0] Output_Pixel_2,
    output logic [DATA_WIDTH-1:0] Output_Pixel_3,
    output logic [DATA_WIDTH-1:0] Output_Pixel_4,
    output logic [DATA_WIDTH-1:0] Output_Pixel_5,
    output logic [DATA_WIDTH-1:0] Output_Pixel_6,
    output logic                  Output_Valid,
    input  logic                  Output_Ready,
    output logic                  Output_Finish,
    output logic                  Overflow
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_len;
    logic              r_s1_vld;
    logic              r_s1_last;
    logic              r_out_vld;
    logic              r_out_fin;
    pix6_t             r_out_pix;
    logic              r_ovf;

    pix6_t             w_wdata;
    pix6_t             w_rdata;
    logic              w_we;
    logic [ADDR_W-1:0] w_wr_next;
    logic              w_fill_done;
    logic              w_out_adv;
    logic              w_ren;
    logic              w_xfer_last;

    assign w_wdata = '{
        ch6: Input_Pixel_6,
        ch5: Input_Pixel_5,
        ch4: Input_Pixel_4,
        ch3: Input_Pixel_3,
        ch2: Input_Pixel_2,
        ch1: Input_Pixel_1
    };

    assign w_we      = (r_state == FILL) && Input_Valid;
    assign w_wr_next = r_wr_cnt + {{(ADDR_W-1){1'b0}}, w_we};

    // Frame ends on the last address or on Finish once something
    // (including the beat written this cycle) has been stored.
    assign w_fill_done = (r_state == FILL)
                       && ((w_we && (r_wr_cnt == LAST_ADDR))
                       || (Input_Finish && (w_wr_next != '0)));

    // Output register may take a new beat when empty or consumed.
    assign w_out_adv = !r_out_vld || Output_Ready;

    // Issue a read while words remain and the RAM stage is free
    // or draining into the output register this cycle.
    assign w_ren = (r_state == DRAIN)
                 && (r_rd_cnt < r_len)
                 && (!r_s1_vld || w_out_adv);

    assign w_xfer_last = r_out_vld && Output_Ready && r_out_fin;

    sampling1_buf_ram u_ram (
        .i_clk   (Clock),
        .i_we    (w_we),
        .i_waddr (r_wr_cnt),
        .i_wdata (w_wdata),
        .i_re    (w_ren),
        .i_raddr (r_rd_cnt),
        .o_rdata (w_rdata)
    );

    // Fill/drain sequencing and the address counters.
    always_ff @(posedge Clock or negedge Input_Reset_n) begin
        if (!Input_Reset_n) begin
            r_state  <= FILL;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_len    <= '0;
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_we) begin
                        r_wr_cnt <= r_wr_cnt + ONE_ADDR;
                    end
                    if (w_fill_done) begin
                        r_len   <= w_wr_next;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_ren) begin
                        r_rd_cnt <= r_rd_cnt + ONE_ADDR;
                    end
                    if (w_xfer_last) begin
                        r_state  <= FILL;
                        r_wr_cnt <= '0;
                        r_rd_cnt <= '0;
                        r_len    <= '0;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    // Two-stage read pipeline: RAM register then output register.
    always_ff @(posedge Clock or negedge Input_Reset_n) begin
        if (!Input_Reset_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_out_vld <= 1'b0;
            r_out_fin <= 1'b0;
            r_out_pix <= '0;
        end else if (w_xfer_last) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_out_vld <= 1'b0;
            r_out_fin <= 1'b0;
        end else begin
            if (w_ren) begin
                r_s1_vld  <= 1'b1;
                r_s1_last <= (r_rd_cnt == (r_len - ONE_ADDR));
            end else if (w_out_adv) begin
                r_s1_vld  <= 1'b0;
            end
            if (w_out_adv) begin
                r_out_vld <= r_s1_vld;
                r_out_fin <= r_s1_vld && r_s1_last;
                if (r_s1_vld) begin
                    r_out_pix <= w_rdata;
                end
            end
        end
    end

    // Sticky flag for beats that arrive while the frame is replaying.
    always_ff @(posedge Clock or negedge Input_Reset_n) begin
        if (!Input_Reset_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == DRAIN) && Input_Valid) begin
            r_ovf <= 1'b1;
        end
    end

    assign Input_Ready    = (r_state == FILL);
    assign Output_Valid   = r_out_vld;
    assign Output_Finish  = r_out_fin;
    assign Overflow       = r_ovf;
    assign Output_Pixel_1 = r_out_pix.ch1;
    assign Output_Pixel_2 = r_out_pix.ch2;
    assign Output_Pixel_3 = r_out_pix.ch3;
    assign Output_Pixel_4 = r_out_pix.ch4;
    assign Output_Pixel_5 = r_out_pix.ch5;
    assign Output_Pixel_6 = r_out_pix.ch6;

endmodule
